// File: rtl/sram_like_responder_pkg.sv
// sram_like_responder_pkg: access-size encodings and the store byte-enable helper
package sram_like_responder_pkg;

   typedef enum logic [1:0] {SIZE_BYTE, SIZE_HALF, SIZE_WORD, SIZE_RSVD} size_e;

   function automatic logic [3:0] size_to_wen(input logic [1:0] size, input logic [1:0] addr_lo);
      return size == SIZE_BYTE ? 4'b0001 << addr_lo :
             size == SIZE_HALF ? (addr_lo[1] ? 4'b1100 : 4'b0011) :
             size == SIZE_WORD ? 4'b1111 : 4'b0000;
   endfunction

endpackage

// File: rtl/sram_like_responder_resp_delay_line.sv
// resp_delay_line: fixed-latency response pipeline carrying valid, write tag and read data
module resp_delay_line #(
   parameter int LATENCY = 1
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        push,
   input  logic        wr,
   input  logic [31:0] ram_rdata,
   output logic        data_ok,
   output logic [31:0] rdata
);

   logic [LATENCY:1] v;
   logic [LATENCY:1] w;
   logic [31:0]      rd;

   // shift the valid and write-tag stages; reset drops everything in flight
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         v <= '0;
         w <= '0;
      end else begin
         v[1] <= push;
         w[1] <= wr;
         for (int k = 2; k <= LATENCY; k++) begin
            v[k] <= v[k-1];
            w[k] <= w[k-1];
         end
      end
   end

   if (LATENCY == 1) begin : g_direct
      assign rd = ram_rdata;
   end else begin : g_pipe
      logic [31:0] d [2:LATENCY];
      // capture RAM data the cycle it is valid, then carry it alongside its valid bit
      always_ff @(posedge clk or negedge resetn) begin
         if (!resetn) begin
            for (int k = 2; k <= LATENCY; k++) d[k] <= '0;
         end else begin
            d[2] <= v[1] ? ram_rdata : d[2];
            for (int k = 3; k <= LATENCY; k++) d[k] <= d[k-1];
         end
      end
      assign rd = d[LATENCY];
   end

   assign data_ok = v[LATENCY];
   assign rdata   = (v[LATENCY] && !w[LATENCY]) ? rd : '0;

endmodule

// File: rtl/sram_like_responder.sv
// sram_like_responder: SRAM-like handshake slave fronting a synchronous single-port RAM
module sram_like_responder
   import sram_like_responder_pkg::*;
#(
   parameter int LATENCY = 1,
   parameter int DEPTH   = 2
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        req,
   input  logic        wr,
   input  logic [1:0]  size,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        addr_ok,
   output logic        data_ok,
   output logic [31:0] rdata,
   output logic        ram_en,
   output logic [3:0]  ram_wen,
   output logic [31:0] ram_addr,
   output logic [31:0] ram_wdata,
   input  logic [31:0] ram_rdata
);

   logic [3:0] cnt;
   logic       accept;

   assign addr_ok   = resetn && (cnt < 4'(DEPTH));
   assign accept    = req && addr_ok;
   assign ram_en    = accept;
   assign ram_wen   = (accept && wr) ? size_to_wen(size, addr[1:0]) : 4'b0000;
   assign ram_addr  = {addr[31:2], 2'b00};
   assign ram_wdata = wdata;

   // outstanding count: up on accept, down on each response
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) cnt <= '0;
      else         cnt <= cnt + {3'b000, accept} - {3'b000, data_ok};
   end

   resp_delay_line #(.LATENCY(LATENCY)) u_dl (
      .clk       (clk),
      .resetn    (resetn),
      .push      (accept),
      .wr        (wr),
      .ram_rdata (ram_rdata),
      .data_ok   (data_ok),
      .rdata     (rdata)
   );

endmodule

// File: tb/tb_sram_like_responder.sv
// tb_sram_like_responder: directed checks of a LATENCY=1 and a LATENCY=3 responder over bench RAMs
module tb_sram_like_responder;

   logic        clk = 0;
   logic        resetn, req, wr;
   logic [1:0]  size;
   logic [31:0] addr, wdata;

   logic        a_ok1, d_ok1, en1, a_ok3, d_ok3, en3;
   logic [31:0] rd1, ad1, wd1, rr1, rd3, ad3, wd3, rr3;
   logic [3:0]  wen1, wen3;

   logic [31:0] m1 [16];
   logic [31:0] m3 [16];

   int checks = 0;
   int errors = 0;

   logic [0:9] ea3 = 10'b1100110011;
   logic [0:9] ee3 = 10'b1100110000;
   logic [0:9] ed3 = 10'b0001100110;
   logic [0:9] ed1 = 10'b0111111000;

   always #5 clk = ~clk;

   sram_like_responder #(.LATENCY(1), .DEPTH(2)) u1 (
      .clk(clk), .resetn(resetn), .req(req), .wr(wr), .size(size), .addr(addr), .wdata(wdata),
      .addr_ok(a_ok1), .data_ok(d_ok1), .rdata(rd1), .ram_en(en1), .ram_wen(wen1),
      .ram_addr(ad1), .ram_wdata(wd1), .ram_rdata(rr1)
   );

   sram_like_responder #(.LATENCY(3), .DEPTH(2)) u3 (
      .clk(clk), .resetn(resetn), .req(req), .wr(wr), .size(size), .addr(addr), .wdata(wdata),
      .addr_ok(a_ok3), .data_ok(d_ok3), .rdata(rd3), .ram_en(en3), .ram_wen(wen3),
      .ram_addr(ad3), .ram_wdata(wd3), .ram_rdata(rr3)
   );

   function automatic logic [31:0] mrg(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
      logic [31:0] r;
      r = o;
      for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
      return r;
   endfunction

   // write-first synchronous RAMs, one per responder
   always @(posedge clk) begin
      if (en1) begin
         m1[ad1[5:2]] <= mrg(m1[ad1[5:2]], wd1, wen1);
         rr1 <= mrg(m1[ad1[5:2]], wd1, wen1);
      end
      if (en3) begin
         m3[ad3[5:2]] <= mrg(m3[ad3[5:2]], wd3, wen3);
         rr3 <= mrg(m3[ad3[5:2]], wd3, wen3);
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 16; i++) begin
         m1[i] = 32'h0;
         m3[i] = 32'h0;
      end
      m1[4] = 32'hDEADBEEF;
      m3[4] = 32'hDEADBEEF;
      rr1 = 0;
      rr3 = 0;
      resetn = 0; req = 1; wr = 1; size = 2; addr = 32'h10; wdata = 32'h0;
      tick(); tick(); #3;
      chk("rst_aok1", a_ok1, 0);
      chk("rst_aok3", a_ok3, 0);
      chk("rst_en1", en1, 0);
      chk("rst_en3", en3, 0);
      chk("rst_wen3", wen3, 0);
      chk("rst_dok3", d_ok3, 0);
      chk("rst_rd3", rd3, 0);
      tick(); resetn = 1; req = 0; wr = 0; #3;
      chk("rel_aok1", a_ok1, 1);
      chk("rel_aok3", a_ok3, 1);
      tick(); req = 1; #3;
      chk("t1_en1", en1, 1);
      chk("t1_ad1", ad1, 32'h10);
      chk("t1_wen1", wen1, 0);
      tick(); req = 0; #3;
      chk("t1_dok1", d_ok1, 1);
      chk("t1_rd1", rd1, 32'hDEADBEEF);
      chk("t1_dok3_early", d_ok3, 0);
      tick(); #3;
      chk("t1_dok1_off", d_ok1, 0);
      chk("t1_rd1_off", rd1, 0);
      chk("t1_rd3_idle", rd3, 0);
      tick(); #3;
      chk("t1_dok3", d_ok3, 1);
      chk("t1_rd3", rd3, 32'hDEADBEEF);
      tick(); #3;
      chk("t1_dok3_off", d_ok3, 0);
      for (int i = 0; i < 10; i++) begin
         tick(); req = (i < 6); #3;
         chk($sformatf("t2_aok3_%0d", i), a_ok3, ea3[i]);
         chk($sformatf("t2_en3_%0d", i), en3, ee3[i]);
         chk($sformatf("t2_dok3_%0d", i), d_ok3, ed3[i]);
         chk($sformatf("t2_dok1_%0d", i), d_ok1, ed1[i]);
         if (ed3[i]) chk($sformatf("t2_rd3_%0d", i), rd3, 32'hDEADBEEF);
      end
      tick(); req = 1; wr = 1; size = 0; addr = 32'h12; wdata = 32'hAAAAAAAA; #3;
      chk("t3_wen3", wen3, 4'b0100);
      chk("t3_wen1", wen1, 4'b0100);
      chk("t3_ad3", ad3, 32'h10);
      chk("t3_wd3", wd3, 32'hAAAAAAAA);
      tick(); wr = 0; size = 2; addr = 32'h10; #3;
      chk("t3_dok1_w", d_ok1, 1);
      chk("t3_rd1_w", rd1, 0);
      chk("t3_wen3_rd", wen3, 0);
      tick(); req = 0; #3;
      chk("t3_dok1_r", d_ok1, 1);
      chk("t3_rd1_r", rd1, 32'hDEAABEEF);
      tick(); #3;
      chk("t3_dok3_w", d_ok3, 1);
      chk("t3_rd3_w", rd3, 0);
      tick(); #3;
      chk("t3_dok3_r", d_ok3, 1);
      chk("t3_rd3_r", rd3, 32'hDEAABEEF);
      tick(); #3;
      chk("t3_dok3_off", d_ok3, 0);
      tick(); req = 1; wr = 1; size = 1; addr = 32'h12; wdata = 32'h55555555; #3;
      chk("t4_wen3_half", wen3, 4'b1100);
      tick(); size = 3; addr = 32'h10; wdata = 32'h0; #3;
      chk("t4_wen3_rsvd", wen3, 4'b0000);
      chk("t4_en3_rsvd", en3, 1);
      tick(); req = 0; wr = 0; size = 2; #3;
      chk("t4_aok3_full", a_ok3, 0);
      tick(); #3;
      chk("t4_dok3_half", d_ok3, 1);
      chk("t4_rd3_half", rd3, 0);
      tick(); #3;
      chk("t4_dok3_rsvd", d_ok3, 1);
      chk("t4_rd3_rsvd", rd3, 0);
      tick(); #3;
      chk("t4_dok3_off", d_ok3, 0);
      tick(); req = 1; #3;
      tick(); #3;
      tick(); req = 0; resetn = 0; #3;
      chk("t5_aok3_rst", a_ok3, 0);
      chk("t5_dok3_rst", d_ok3, 0);
      tick(); resetn = 1; #3;
      chk("t5_aok3_rel", a_ok3, 1);
      for (int i = 0; i < 4; i++) begin
         tick(); #3;
         chk($sformatf("t5_dok3_drop_%0d", i), d_ok3, 0);
         chk($sformatf("t5_dok1_drop_%0d", i), d_ok1, 0);
      end
      tick(); req = 1; #3;
      tick(); req = 0; #3;
      chk("t5_dok1", d_ok1, 1);
      chk("t5_rd1", rd1, 32'h5555BEEF);
      tick(); #3;
      tick(); #3;
      chk("t5_dok3", d_ok3, 1);
      chk("t5_rd3", rd3, 32'h5555BEEF);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
